// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Shares the single register-file write port between the in-order
//            pipeline writeback (A, never back-pressured) and a long-latency
//            unit (B, valid/ready). B results are queued in a small FIFO that
//            drains on cycles A leaves free. A bounded-wait counter requests a
//            pipeline stall so B cannot starve. Address-match flags let decode
//            hold on reads of destinations still waiting in the FIFO.
// Ports    : clk, rst (async, active-low)
//            a_we/a_waddr/a_wdata        source A write request
//            b_valid/b_ready/b_waddr/b_wdata  source B handshake
//            we/waddr/wdata              registered regfile write port
//            stall_req                   registered pipeline stall request
//            raddr1/raddr2 -> pend_hit1/pend_hit2  pending-destination flags
//            b_count                     FIFO occupancy
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a_we,
  input  logic [4:0]               a_waddr,
  input  logic [31:0]              a_wdata,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [4:0]               b_waddr,
  input  logic [31:0]              b_wdata,
  output logic                     we,
  output logic [4:0]               waddr,
  output logic [31:0]              wdata,
  output logic                     stall_req,
  input  logic [4:0]               raddr1,
  input  logic [4:0]               raddr2,
  output logic                     pend_hit1,
  output logic                     pend_hit2,
  output logic [$clog2(DEPTH):0]   b_count
);

  localparam int         AW    = $clog2(DEPTH);
  localparam int         CW    = AW + 1;
  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  logic [4:0]    fifo_addr [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [3:0]    wcnt;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic a_win;

  logic [DEPTH-1:0] hit1_vec;
  logic [DEPTH-1:0] hit2_vec;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // Ready looks only at the registered count, never at a same-cycle pop.
  assign b_ready = !full;
  // Results for r0 complete the handshake but are never stored.
  assign push    = b_valid && !full && (b_waddr != 5'd0);
  assign a_win   = a_we && (a_waddr != 5'd0);
  assign pop     = !a_win && !empty;

  assign count_next = count + CW'(push) - CW'(pop);
  assign b_count    = count;

  // An entry is live when its distance from the read pointer is below count.
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_hit
      logic [AW-1:0] off;
      logic          live;
      assign off         = AW'(i) - rd_ptr;
      assign live        = ({1'b0, off} < count);
      assign hit1_vec[i] = live && (fifo_addr[i] == raddr1);
      assign hit2_vec[i] = live && (fifo_addr[i] == raddr2);
    end
  endgenerate

  assign pend_hit1 = (raddr1 != 5'd0) && (|hit1_vec);
  assign pend_hit2 = (raddr2 != 5'd0) && (|hit2_vec);

  // Storage needs no reset: liveness comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= b_waddr;
      fifo_data[wr_ptr] <= b_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      wcnt      <= '0;
      we        <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
      stall_req <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;

      if (a_win) begin
        we    <= 1'b1;
        waddr <= a_waddr;
        wdata <= a_wdata;
      end else if (pop) begin
        we    <= 1'b1;
        waddr <= fifo_addr[rd_ptr];
        wdata <= fifo_data[rd_ptr];
      end else begin
        we    <= 1'b0;
      end

      // Counts consecutive A wins that keep a queued B result waiting.
      if (pop || empty) begin
        wcnt <= '0;
      end else if (a_win && (wcnt != MAX_W)) begin
        wcnt <= wcnt + 4'd1;
      end

      // Stall holds until the pop that empties the FIFO has happened.
      if (count_next == '0) begin
        stall_req <= 1'b0;
      end else if (wcnt == MAX_W) begin
        stall_req <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Self-checking bench for regfile_wb_arbiter. A queue-based
//            reference model tracks the expected write port, FIFO contents,
//            wait budget and stall every cycle; directed vector tables and
//            hand-written sequences cover the documented corner cases.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_we;
  logic [4:0]  a_waddr;
  logic [31:0] a_wdata;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_waddr;
  logic [31:0] b_wdata;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        stall_req;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        pend_hit1;
  logic        pend_hit2;
  logic [$clog2(DEPTH):0] b_count;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .a_we(a_we), .a_waddr(a_waddr), .a_wdata(a_wdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_waddr(b_waddr), .b_wdata(b_wdata),
    .we(we), .waddr(waddr), .wdata(wdata), .stall_req(stall_req),
    .raddr1(raddr1), .raddr2(raddr2),
    .pend_hit1(pend_hit1), .pend_hit2(pend_hit2), .b_count(b_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  typedef struct {
    logic        a_we;
    logic [4:0]  a_waddr;
    logic [31:0] a_wdata;
    logic        b_valid;
    logic [4:0]  b_waddr;
    logic [31:0] b_wdata;
    logic [4:0]  raddr1;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic [1:0]  e_cnt;
    logic        e_hit1;
  } vec_t;

  // Reference model state
  ent_t        mq[$];
  int          m_w;
  bit          m_stall;
  bit          m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  bit          m_acc;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit m_hit(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (mq[k]) if (mq[k].a == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_w = 0; m_stall = 0; m_we = 0; m_waddr = '0; m_wdata = '0; m_acc = 0;
  endtask

  task automatic check_all();
    chk("we", we, m_we);
    chk("waddr", waddr, m_waddr);
    chk("wdata", wdata, m_wdata);
    chk("stall_req", stall_req, m_stall);
    chk("b_count", b_count, mq.size());
    chk("b_ready", b_ready, mq.size() < DEPTH);
    chk("pend_hit1", pend_hit1, m_hit(raddr1));
    chk("pend_hit2", pend_hit2, m_hit(raddr2));
  endtask

  // Advance the model by one cycle from the current inputs, clock, compare.
  task automatic tick();
    bit ready, push, awin, pop;
    int old_size, old_w;
    ready    = mq.size() < DEPTH;
    m_acc    = b_valid && ready;
    push     = m_acc && (b_waddr != 5'd0);
    awin     = a_we && (a_waddr != 5'd0);
    old_size = mq.size();
    old_w    = m_w;
    pop      = !awin && (old_size > 0);
    if (awin) begin
      m_we = 1; m_waddr = a_waddr; m_wdata = a_wdata;
    end else if (pop) begin
      m_we = 1; m_waddr = mq[0].a; m_wdata = mq[0].d;
    end else begin
      m_we = 0;
    end
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back('{b_waddr, b_wdata});
    if (pop || old_size == 0) m_w = 0;
    else if (awin && m_w < MAX_WAIT) m_w = m_w + 1;
    if (mq.size() == 0) m_stall = 0;
    else if (old_w == MAX_WAIT) m_stall = 1;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    a_we = 0; a_waddr = '0; a_wdata = '0;
    b_valid = 0; b_waddr = '0; b_wdata = '0;
    raddr1 = '0; raddr2 = '0;
  endtask

  vec_t tbl[9];
  ent_t got[$];
  ent_t exp_q[$];

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'h0,  5'd0, 1'b1, 5'd5, 32'h11, 2'd0, 1'b0};
    tbl[1] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd0, 1'b0, 5'd5, 32'h11, 2'd0, 1'b0};
    tbl[2] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd7, 32'hAB, 5'd7, 1'b0, 5'd5, 32'h11, 2'd1, 1'b1};
    tbl[3] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd7, 1'b1, 5'd7, 32'hAB, 2'd0, 1'b0};
    tbl[4] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd0, 1'b0, 5'd7, 32'hAB, 2'd0, 1'b0};
    tbl[5] = '{1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 5'd4, 1'b1, 5'd3, 32'h33, 2'd1, 1'b1};
    tbl[6] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd4, 1'b1, 5'd4, 32'h44, 2'd0, 1'b0};
    tbl[7] = '{1'b1, 5'd0, 32'h99, 1'b1, 5'd0, 32'h88, 5'd0, 1'b0, 5'd4, 32'h44, 2'd0, 1'b0};
    tbl[8] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd0, 1'b0, 5'd4, 32'h44, 2'd0, 1'b0};

    // Reset state
    idle_inputs();
    raddr1 = 5'd5;
    rst = 1'b0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst = 1'b1;
    raddr1 = '0;

    // Directed vectors: A alone, B alone, collision, r0 writes
    for (int i = 0; i < 9; i++) begin
      a_we = tbl[i].a_we; a_waddr = tbl[i].a_waddr; a_wdata = tbl[i].a_wdata;
      b_valid = tbl[i].b_valid; b_waddr = tbl[i].b_waddr; b_wdata = tbl[i].b_wdata;
      raddr1 = tbl[i].raddr1;
      tick();
      chk($sformatf("vec%0d_we", i), we, tbl[i].e_we);
      chk($sformatf("vec%0d_waddr", i), waddr, tbl[i].e_waddr);
      chk($sformatf("vec%0d_wdata", i), wdata, tbl[i].e_wdata);
      chk($sformatf("vec%0d_cnt", i), b_count, tbl[i].e_cnt);
      chk($sformatf("vec%0d_hit1", i), pend_hit1, tbl[i].e_hit1);
    end
    idle_inputs();

    // Full / back-pressure / stall / in-order drain
    a_we = 1; a_waddr = 5'd1; a_wdata = 32'hA1;
    b_valid = 1; b_waddr = 5'd10; b_wdata = 32'hB10;
    tick();
    b_waddr = 5'd11; b_wdata = 32'hB11;
    tick();
    chk("full_ready", b_ready, 1'b0);
    chk("full_count", b_count, 2);
    b_waddr = 5'd12; b_wdata = 32'hB12;
    repeat (MAX_WAIT - 1) tick();
    chk("stall_early", stall_req, 1'b0);
    chk("held_count", b_count, 2);
    tick();
    chk("stall_rise", stall_req, 1'b1);
    a_we = 0;
    got.delete();
    for (int i = 0; i < 20 && (b_valid || b_count != 0); i++) begin
      tick();
      if (m_acc) b_valid = 0;
      if (we && waddr >= 5'd10) got.push_back('{waddr, wdata});
    end
    chk("stall_fall", stall_req, 1'b0);
    chk("drain_n", got.size(), 3);
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      chk($sformatf("drain%0d_addr", i), got[i].a, 10 + i);
      chk($sformatf("drain%0d_data", i), got[i].d, 32'hB10 + i);
    end
    idle_inputs();

    // Wrap-around: 10 B results with alternating A traffic
    got.delete();
    exp_q.delete();
    begin
      int sent = 0;
      for (int cyc = 0; cyc < 200; cyc++) begin
        if (!b_valid && sent < 10) begin
          b_valid = 1; b_waddr = 5'(16 + sent); b_wdata = $urandom;
          exp_q.push_back('{b_waddr, b_wdata});
          sent++;
        end
        a_we = cyc[0] && !m_stall; a_waddr = 5'(1 + cyc % 3); a_wdata = $urandom;
        raddr1 = b_waddr;
        tick();
        if (m_acc) b_valid = 0;
        if (we && waddr >= 5'd16) got.push_back('{waddr, wdata});
        if (sent == 10 && !b_valid && b_count == 0) break;
      end
    end
    chk("wrap_n", got.size(), 10);
    for (int i = 0; i < 10 && i < got.size(); i++) begin
      chk($sformatf("wrap%0d_addr", i), got[i].a, exp_q[i].a);
      chk($sformatf("wrap%0d_data", i), got[i].d, exp_q[i].d);
    end
    idle_inputs();
    tick();

    // Asynchronous reset with two entries pending and stall raised
    a_we = 1; a_waddr = 5'd2; a_wdata = 32'hC2;
    b_valid = 1; b_waddr = 5'd20; b_wdata = 32'hD20;
    tick();
    b_waddr = 5'd21; b_wdata = 32'hD21;
    tick();
    b_valid = 0;
    repeat (MAX_WAIT) tick();
    chk("prerst_stall", stall_req, 1'b1);
    chk("prerst_count", b_count, 2);
    chk("prerst_we", we, 1'b1);
    raddr1 = 5'd20; raddr2 = 5'd21;
    #1;
    chk("prerst_hit1", pend_hit1, 1'b1);
    chk("prerst_hit2", pend_hit2, 1'b1);
    a_we = 0;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_we", we, 1'b0);
    chk("arst_count", b_count, 0);
    chk("arst_stall", stall_req, 1'b0);
    chk("arst_hit1", pend_hit1, 1'b0);
    chk("arst_hit2", pend_hit2, 1'b0);
    chk("arst_ready", b_ready, 1'b1);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    check_all();

    // Randomized traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      a_we    = ($urandom % 2 == 0) && !m_stall;
      a_waddr = 5'($urandom % 8);
      a_wdata = $urandom;
      b_valid = ($urandom % 3 != 0);
      b_waddr = 5'($urandom % 8);
      b_wdata = $urandom;
      raddr1  = 5'($urandom % 8);
      raddr2  = 5'($urandom % 8);
      tick();
    end
    idle_inputs();
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
